ysyx_24070016_mem_arbiter: RTL and testbench
============================================

# ysyx_24070016_mem_arbiter

Two-requester memory arbiter and transaction sequencer for the ysyx_24070016 core. It shares a single downstream memory port between the IFU (read-only fetch) and the LSU (load/store), and converts the core's single-cycle memory access into a valid/ready request/response protocol. It allows one outstanding transaction at a time, uses round-robin arbitration, and has a watchdog that returns an error response if memory stalls. It sits between the IFU/LSU and the external memory interface in ysyx_24070016_top.

## Interface
- TIMEOUT, default 16: max cycles in ISSUE+WAIT before an error response; 0 disables the watchdog.
- ERR_RDATA, default 32'h0: rdata returned on timeout.

Ports (all 1 bit unless stated):
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  32  fetch address
- ifu_rsp_valid  out  1  IFU response available
- ifu_rsp_ready  in  1  IFU consumes response
- ifu_rsp_rdata  out  32  fetched instruction
- ifu_rsp_err  out  1  response is a timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  32  access address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  32  store data
- lsu_req_wstrb  in  4  byte strobes (stores only)
- lsu_rsp_valid  out  1  LSU response available; also acknowledges stores
- lsu_rsp_ready  in  1  LSU consumes response
- lsu_rsp_rdata  out  32  load data
- lsu_rsp_err  out  1  response is a timeout error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  32  registered write data
- mem_wstrb  out  4  registered strobes; 4'h0 for IFU reads
- mem_rsp_valid  in  1  memory response/ack
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: pick a requester. If only one valid, grant it. If both valid, grant the one not in last_grant. Assert the granted *_req_ready combinationally. On handshake, latch owner, addr, wen, wdata and wstrb; update last_grant; go to ISSUE.
- ISSUE: mem_req_valid=1 with the latched fields. On mem_req_ready go to WAIT. A mem_rsp_valid in the same cycle as mem_req_ready goes straight to RESP.
- WAIT: on mem_rsp_valid, latch mem_rdata into rsp_data, err=0, go to RESP.
- RESP: assert owner's *_rsp_valid with rsp_data and err; the other requester's rsp_valid=0. On owner's *_rsp_ready go to IDLE.
- Watchdog: wd_cnt clears on entry to ISSUE and increments each cycle in ISSUE/WAIT. When wd_cnt==TIMEOUT-1 and no completion occurs that cycle, go to RESP with err=1 and rsp_data=ERR_RDATA; mem_req_valid drops. Completion in the same cycle as expiry wins (err=0).
- mem_rsp_valid outside ISSUE/WAIT is ignored. Late responses after a timeout are dropped.
- *_req_ready is 0 outside IDLE. Requesters must hold their request fields stable while valid.

## Timing
- Reset values: all *_req_ready=0, *_rsp_valid=0, *_rsp_err=0, *_rsp_rdata=0, mem_req_valid=0, mem_addr/mem_wdata=0, mem_wen=0, mem_wstrb=0, wd_cnt=0. last_grant resets to LSU, so the first tie goes to IFU.
- Minimum latency with memory ready and a 1-cycle response:
  - cycle 0: request handshake
  - cycle 1: mem_req_valid and mem_req_ready
  - cycle 2: mem_rsp_valid
  - cycle 3: rsp_valid
- The next request handshake occurs no earlier than the cycle after the response handshake (IDLE).
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values; the transaction is lost.
- rsp_valid is held until rsp_ready, with no upper bound. The watchdog does not run in RESP.

## Structure
- Shared header/package ysyx_24070016_defs holds:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - requester IDs (ID_IFU=1'b0, ID_LSU=1'b1)
  - the ERR_RDATA default
- One natural sub-module: ysyx_24070016_rr_pick2, a combinational two-way round-robin picker (inputs: two valids, last_grant; outputs: grant, grant_valid).
- Holding registers may reuse ysyx_24070016_Reg.

## Test plan
- Single IFU read, memory ready immediately with 1-cycle response, mem_rdata=32'h00000413 -> ifu_rsp_valid at cycle 3, rdata=32'h00000413, err=0; lsu_rsp_valid stays 0.
- IFU and LSU valid together right after reset -> IFU granted first; LSU is granted in the first IDLE after the IFU response handshake. Back-to-back ties then alternate IFU, LSU, IFU.
- LSU store: addr=32'h80001000, wdata=32'hCAFEBABE, wstrb=4'b0011 -> mem_wen=1 and the exact fields appear on the mem port; lsu_rsp_valid acks with err=0.
- Memory never asserts mem_rsp_valid, TIMEOUT=16 -> owner rsp_valid with err=1, rdata=ERR_RDATA, exactly 16 cycles after ISSUE entry. A late mem_rsp_valid is then ignored.
- mem_req_ready low for 5 cycles, then response; rsp_ready held low 3 cycles -> mem fields and rsp_valid/rdata stay stable throughout, and no new grant occurs.
- rst pulsed low while in WAIT -> all outputs go to reset values asynchronously; after release, a new IFU request completes normally.

Source files
------------

// File: rtl/ysyx_24070016_defs.sv
// Shared definitions for the ysyx_24070016 memory arbiter: FSM encoding,
// requester IDs and the default error read data.
package ysyx_24070016_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0;

endpackage

// File: rtl/ysyx_24070016_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the requester that was
// not granted last wins.
module ysyx_24070016_rr_pick2
  import ysyx_24070016_defs::*;
(
  input  logic valid_ifu,
  input  logic valid_lsu,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  always_comb begin
    grant_valid = valid_ifu | valid_lsu;
    if (valid_ifu && valid_lsu) begin
      grant = ~last_grant;
    end else if (valid_lsu) begin
      grant = ID_LSU;
    end else begin
      grant = ID_IFU;
    end
  end

endmodule

// File: rtl/ysyx_24070016_mem_arbiter.sv
// IFU/LSU memory arbiter: one outstanding valid/ready transaction, round-robin
// grant, and a watchdog that answers with an error response if memory stalls.
module ysyx_24070016_mem_arbiter
  import ysyx_24070016_defs::*;
#(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [31:0] ifu_rsp_rdata,
  output logic        ifu_rsp_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wstrb,
  output logic        lsu_rsp_valid,
  input  logic        lsu_rsp_ready,
  output logic [31:0] lsu_rsp_rdata,
  output logic        lsu_rsp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  localparam logic        WD_ON   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        err_q, err_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;

  logic grant;
  logic grant_valid;
  logic done;
  logic expire;
  logic owner_rsp_ready;

  ysyx_24070016_rr_pick2 u_pick (
    .valid_ifu   (ifu_req_valid),
    .valid_lsu   (lsu_req_valid),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Completion beats expiry when both land in the same cycle.
  assign done   = (state_q == ST_ISSUE) ? (mem_req_ready && mem_rsp_valid)
                                        : mem_rsp_valid;
  assign expire = WD_ON && (wd_cnt_q == WD_LAST);
  assign owner_rsp_ready = (owner_q == ID_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rsp_data_d   = rsp_data_q;
    err_d        = err_q;
    wd_cnt_d     = wd_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d      = grant;
          last_grant_d = grant;
          wd_cnt_d     = 32'd0;
          state_d      = ST_ISSUE;
          if (grant == ID_LSU) begin
            addr_d  = lsu_req_addr;
            wen_d   = lsu_req_wen;
            wdata_d = lsu_req_wdata;
            wstrb_d = lsu_req_wstrb;
          end else begin
            addr_d  = ifu_req_addr;
            wen_d   = 1'b0;
            wdata_d = 32'd0;
            wstrb_d = 4'h0;
          end
        end
      end
      ST_ISSUE, ST_WAIT: begin
        wd_cnt_d = wd_cnt_q + 32'd1;
        if (done) begin
          rsp_data_d = mem_rdata;
          err_d      = 1'b0;
          state_d    = ST_RESP;
        end else if (expire) begin
          rsp_data_d = ERR_RDATA;
          err_d      = 1'b1;
          state_d    = ST_RESP;
        end else if (state_q == ST_ISSUE && mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= ID_IFU;
      last_grant_q <= ID_LSU;
      addr_q       <= 32'd0;
      wen_q        <= 1'b0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'h0;
      rsp_data_q   <= 32'd0;
      err_q        <= 1'b0;
      wd_cnt_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  // Ready is combinational from the requests, so it is also masked by reset.
  assign ifu_req_ready = rst && (state_q == ST_IDLE) && grant_valid && (grant == ID_IFU);
  assign lsu_req_ready = rst && (state_q == ST_IDLE) && grant_valid && (grant == ID_LSU);

  assign ifu_rsp_valid = (state_q == ST_RESP) && (owner_q == ID_IFU);
  assign lsu_rsp_valid = (state_q == ST_RESP) && (owner_q == ID_LSU);
  assign ifu_rsp_rdata = rsp_data_q;
  assign lsu_rsp_rdata = rsp_data_q;
  assign ifu_rsp_err   = ifu_rsp_valid && err_q;
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

endmodule

// File: tb/tb_ysyx_24070016_mem_arbiter.sv
// Scoreboard bench for ysyx_24070016_mem_arbiter with a behavioural memory
// whose accept delay, muting and late-response injection are bench-controlled.
`timescale 1ns/1ps
module tb_ysyx_24070016_mem_arbiter;

  localparam logic [31:0] ERR_VAL = 32'hBAD0_0BAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_rdata;
  logic        ifu_rsp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  ysyx_24070016_mem_arbiter #(.TIMEOUT(16), .ERR_RDATA(ERR_VAL)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          ready_delay = 0;
  logic        mem_mute    = 1'b0;
  int          late_req    = 0;
  logic [31:0] next_rdata  = 32'd0;
  logic [31:0] cap_addr  = 32'd0;
  logic        cap_wen   = 1'b0;
  logic [31:0] cap_wdata = 32'd0;
  logic [3:0]  cap_wstrb = 4'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory model: acts at negedges, driving inputs for the next rising edge.
  initial begin
    int   stall     = 0;
    int   late_seen = 0;
    logic pend      = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'd0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (!rst) begin
        stall = 0;
        pend  = 1'b0;
      end else if (late_req != late_seen) begin
        late_seen     = late_req;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
      end else if (pend) begin
        pend = 1'b0;
        if (!mem_mute) begin
          mem_rsp_valid = 1'b1;
          mem_rdata     = next_rdata;
        end
      end else if (mem_req_valid) begin
        if (stall >= ready_delay) begin
          mem_req_ready = 1'b1;
          pend      = 1'b1;
          stall     = 0;
          cap_addr  = mem_addr;
          cap_wen   = mem_wen;
          cap_wdata = mem_wdata;
          cap_wstrb = mem_wstrb;
        end else begin
          stall++;
        end
      end
    end
  end

  // Raise a request, wait for the grant, record the expected response and
  // return one cycle after the handshake (first ISSUE cycle).
  task automatic send(input logic who, input logic [31:0] addr, input logic wen,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] rdata, input logic err);
    int   t = 0;
    exp_t e;
    if (who) begin
      lsu_req_valid = 1'b1; lsu_req_addr = addr; lsu_req_wen = wen;
      lsu_req_wdata = wdata; lsu_req_wstrb = wstrb;
    end else begin
      ifu_req_valid = 1'b1; ifu_req_addr = addr;
    end
    next_rdata = rdata;
    #1;
    while (!(who ? lsu_req_ready : ifu_req_ready) && t < 50) begin
      cyc(1);
      #1;
      t++;
    end
    chk("req_accept", 64'(who ? lsu_req_ready : ifu_req_ready), 64'd1);
    e.owner = who;
    e.rdata = err ? ERR_VAL : rdata;
    e.err   = err;
    exp_q.push_back(e);
    cyc(1);
    if (who) lsu_req_valid = 1'b0;
    else     ifu_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output int waited);
    exp_t        e;
    logic        who;
    logic [31:0] rd0;
    waited = 0;
    while (!(ifu_rsp_valid || lsu_rsp_valid) && waited < 200) begin
      cyc(1);
      waited++;
    end
    chk("rsp_arrived", 64'(ifu_rsp_valid || lsu_rsp_valid), 64'd1);
    if (!(ifu_rsp_valid || lsu_rsp_valid)) return;
    chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    e   = exp_q.pop_front();
    who = lsu_rsp_valid;
    rd0 = who ? lsu_rsp_rdata : ifu_rsp_rdata;
    chk("rsp_owner", 64'(who), 64'(e.owner));
    chk("rsp_exclusive", 64'(ifu_rsp_valid & lsu_rsp_valid), 64'd0);
    chk("rsp_rdata", 64'(rd0), 64'(e.rdata));
    chk("rsp_err", 64'(who ? lsu_rsp_err : ifu_rsp_err), 64'(e.err));
    for (int h = 0; h < hold; h++) begin
      cyc(1);
      chk("rsp_hold", {31'd0, (who ? lsu_rsp_valid : ifu_rsp_valid),
                       (who ? lsu_rsp_rdata : ifu_rsp_rdata)}, {31'd0, 1'b1, rd0});
      chk("no_grant_in_resp", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    end
    if (who) lsu_rsp_ready = 1'b1;
    else     ifu_rsp_ready = 1'b1;
    cyc(1);
    ifu_rsp_ready = 1'b0;
    lsu_rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, 64'({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                  ifu_rsp_err, lsu_rsp_err, mem_req_valid, mem_wen, mem_wstrb}), 64'd0);
    chk({tag, "_data"}, {mem_addr, mem_wdata}, 64'd0);
    chk({tag, "_rdata"}, {ifu_rsp_rdata, lsu_rsp_rdata}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int   w;
    logic g;
    rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0800; lsu_req_wen = 1'b0;
    lsu_req_wdata = 32'd0; lsu_req_wstrb = 4'h0; lsu_rsp_ready = 1'b0;

    // Reset with both requests pending: everything must read as reset values.
    cyc(3);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Continuous tie: IFU first after reset, then strict alternation.
    g = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      next_rdata = 32'h1000_0000 + 32'(k);
      chk("tie_grant", 64'({ifu_req_ready, lsu_req_ready}), g ? 64'd1 : 64'd2);
      e.owner = g; e.rdata = next_rdata; e.err = 1'b0;
      exp_q.push_back(e);
      cyc(1);
      wait_rsp(0, w);
      g = ~g;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    // Single IFU read at minimum latency.
    send(1'b0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 32'h0000_0413, 1'b0);
    wait_rsp(0, w);
    chk("ifu_latency", 64'(w + 1), 64'd3);
    chk("ifu_mem_fields", {cap_addr, 27'd0, cap_wen, cap_wstrb}, {32'h8000_0010, 32'd0});

    // LSU store.
    send(1'b1, 32'h8000_1000, 1'b1, 32'hCAFE_BABE, 4'b0011, 32'h0, 1'b0);
    wait_rsp(0, w);
    chk("st_addr", 64'(cap_addr), 64'h8000_1000);
    chk("st_ctl", 64'({cap_wen, cap_wstrb, cap_wdata}), 64'({1'b1, 4'b0011, 32'hCAFE_BABE}));

    // Memory stalls the request for 5 cycles, IFU waits behind it, LSU holds off ready.
    ready_delay = 5;
    send(1'b1, 32'h8000_2000, 1'b0, 32'd0, 4'h0, 32'h7777_0001, 1'b0);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0040;
    for (int k = 0; k < 5; k++) begin
      chk("stall_fields", {mem_req_valid, mem_wen, mem_wstrb, 26'd0, mem_addr},
                          {1'b1, 1'b0, 4'h0, 26'd0, 32'h8000_2000});
      chk("stall_no_grant", 64'(ifu_req_ready), 64'd0);
      cyc(1);
    end
    wait_rsp(3, w);
    ready_delay = 0;
    send(1'b0, 32'h8000_0040, 1'b0, 32'd0, 4'h0, 32'h0000_0013, 1'b0);
    wait_rsp(0, w);

    // Memory accepts but never answers: watchdog fires 16 cycles after ISSUE entry.
    mem_mute = 1'b1;
    send(1'b1, 32'h8000_3000, 1'b0, 32'd0, 4'h0, 32'h1111_2222, 1'b1);
    wait_rsp(0, w);
    chk("wd_cycles", 64'(w), 64'd16);
    mem_mute = 1'b0;
    late_req++;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("late_drop", 64'({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}), 64'd0);
    end
    send(1'b0, 32'h8000_0050, 1'b0, 32'd0, 4'h0, 32'h0000_0093, 1'b0);
    wait_rsp(0, w);
    chk("after_wd_latency", 64'(w + 1), 64'd3);

    // Reset pulse while in WAIT.
    mem_mute = 1'b1;
    send(1'b0, 32'h8000_0100, 1'b0, 32'd0, 4'h0, 32'h5555_5555, 1'b0);
    cyc(1);
    ifu_req_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    cyc(2);
    rst = 1'b1;
    mem_mute = 1'b0;
    send(1'b0, 32'h8000_0104, 1'b0, 32'd0, 4'h0, 32'h0000_0513, 1'b0);
    wait_rsp(0, w);
    chk("post_rst_latency", 64'(w + 1), 64'd3);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
